acc_store_unit: RTL and testbench
=================================

Name: acc_store_unit

Overview:
- Downstream consumer of the accumulator. On a store request it captures the 12-bit AC value and the Z flag from the ALU.
- Writes AC to data memory as two 8-bit bytes, little-endian: low byte first, then the high nibble zero-extended.
- Each byte uses a we/ack handshake. Completion is reported to the control unit with a one-cycle done pulse.

Parameters:
- ACW, 12, accumulator width (bits 11:8 form the high nibble).
- DW, 8, memory data width.
- AW, 8, memory address width.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- st_req  input  1  store request; sampled only in IDLE.
- st_addr  input  AW  base address of the store; captured with AC.
- AC  input  ACW  accumulator value from the ALU.
- Z_in  input  1  ALU zero flag; captured with AC.
- busy  output  1  high whenever state is not IDLE.
- st_done  output  1  one-cycle completion pulse.
- z_cap  output  1  Z_in as captured at request acceptance.
- ovf  output  1  captured AC exceeded 8 bits (only with macro).
- mem_addr  output  AW  memory write address.
- mem_wdata  output  DW  memory write data.
- mem_we  output  1  write strobe; held until acknowledged.
- mem_ack  input  1  memory write acknowledge.

Behaviour:
- Reset values: busy=0, st_done=0, z_cap=0, ovf=0, mem_we=0, mem_addr=0, mem_wdata=0, state=IDLE, internal AC/addr capture registers=0.
- States: IDLE, WR_LO, WR_HI, DONE. All outputs are registered.
- IDLE:
  - If st_req=1 at an edge: capture ac_q<=AC, addr_q<=st_addr, z_cap<=Z_in; go to WR_LO.
  - On that same edge drive mem_we=1, mem_addr=st_addr, mem_wdata=AC[7:0].
  - mem_ack is ignored in IDLE.
- WR_LO:
  - Hold mem_we/mem_addr/mem_wdata stable until mem_ack=1 at an edge.
  - On that edge go to WR_HI: mem_addr<=addr_q+1 (wraps modulo 2^AW, 0xFF->0x00), mem_wdata<={4'd0,ac_q[11:8]}, mem_we stays 1.
- WR_HI:
  - Hold until mem_ack=1 at an edge.
  - On that edge go to DONE: mem_we<=0, st_done<=1.
- DONE:
  - Lasts exactly one cycle, with busy=1 and st_done=1.
  - Next edge: st_done<=0, go to IDLE, busy<=0.
- Latency with mem_ack permanently high:
  - req sampled at edge E0; mem_we high from E0 to E2.
  - st_done high from E2 to E3; busy low after E3.
  - A new st_req is accepted at E3 at the earliest.
- st_req while busy is ignored; it is not queued. The requester must hold or re-issue it.
- AC/Z_in changing after capture has no effect on the store in progress.
- mem_addr, mem_wdata and mem_we never change while mem_we=1 and mem_ack=0.
- rst mid-operation: on that edge the unit returns to IDLE.
  - mem_we drops to 0 and st_done is 0.
  - The partial write is abandoned; no done pulse is issued.
- rst has priority over st_req and mem_ack on the same edge.
- z_cap and ovf hold their values until the next accepted request.

Optional Feature:
- Macro: ACC_STORE_SAT_EN.
- Defined:
  - At acceptance, ovf<=(AC[11:8]!=0).
  - If ovf, WR_LO writes 8'hFF (saturated) and, on ack, goes directly to DONE, skipping WR_HI. The store is a single byte.
  - If not ovf, behaviour is the normal two-byte sequence.
- Not defined:
  - ovf is tied 0.
  - Every store is two bytes, unsaturated.

Test Plan:
- AC=12'h3A5, st_addr=8'h10, mem_ack tied 1, st_req pulse -> writes (0x10,0xA5) then (0x11,0x03); st_done high exactly 1 cycle, 3 edges after request; busy falls 1 edge later.
- st_addr=8'hFF, AC=12'h123 -> writes (0xFF,0x23) then (0x00,0x01); the address wraps.
- mem_ack delayed 4 cycles per byte -> mem_we/mem_addr/mem_wdata stable throughout the wait; st_req pulses during busy are ignored (exactly 2 writes, 1 st_done).
- Z_in=1 with AC=0 at request, then AC/Z_in change mid-store -> z_cap=1; written bytes are 0x00, 0x00.
- rst asserted while in WR_HI with ack low -> next edge mem_we=0, busy=0, st_done never pulses; a following request completes normally.
- ACC_STORE_SAT_EN defined, AC=12'h1F0 -> single write (addr,0xFF), ovf=1, st_done 2 edges after request; AC=12'h0F0 -> two writes, ovf=0.

Source files
------------

// File: rtl/acc_store_if.sv
// Bundles the store-request, status and memory write-port signals of acc_store_unit.
// The unit uses the slave modport. The requester/memory side uses the master modport.
interface acc_store_if #(
  parameter int ACW = 12,
  parameter int DW  = 8,
  parameter int AW  = 8
);
  logic           st_req;
  logic [AW-1:0]  st_addr;
  logic [ACW-1:0] AC;
  logic           Z_in;
  logic           busy;
  logic           st_done;
  logic           z_cap;
  logic           ovf;
  logic [AW-1:0]  mem_addr;
  logic [DW-1:0]  mem_wdata;
  logic           mem_we;
  logic           mem_ack;

  modport slave (
    input  st_req, st_addr, AC, Z_in, mem_ack,
    output busy, st_done, z_cap, ovf, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output st_req, st_addr, AC, Z_in, mem_ack,
    input  busy, st_done, z_cap, ovf, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/acc_store_unit.sv
// Captures AC/Z on a store request and writes AC to memory as two little-endian bytes.
// The optional macro ACC_STORE_SAT_EN enables saturated single-byte stores when AC exceeds 8 bits.
module acc_store_unit #(
  parameter int ACW = 12,
  parameter int DW  = 8,
  parameter int AW  = 8
) (
  input  logic         clk,
  input  logic         rst,
  acc_store_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, WR_LO, WR_HI, DONE} state_t;

  state_t          state_q, state_n;
  logic [ACW-1:0]  ac_q, ac_n;
  logic [AW-1:0]   addr_q, addr_n;
  logic            z_q, z_n;
  logic            ovf_q, ovf_n;
  logic            we_q, we_n;
  logic [AW-1:0]   maddr_q, maddr_n;
  logic [DW-1:0]   wdata_q, wdata_n;
  logic            done_q, done_n;
  logic            busy_q, busy_n;
  logic            sat_acc;

  function automatic logic ovf_of(input logic [ACW-1:0] ac);
    return |ac[ACW-1:8];
  endfunction

  function automatic logic [DW-1:0] lo_byte(input logic [ACW-1:0] ac, input logic sat);
    return sat ? {DW{1'b1}} : ac[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] hi_byte(input logic [ACW-1:0] ac);
    return {{(DW-(ACW-8)){1'b0}}, ac[ACW-1:8]};
  endfunction

  // Without saturation, sat_acc is constant 0, so ovf_q never leaves its reset value.
`ifdef ACC_STORE_SAT_EN
  assign sat_acc = ovf_of(bus.AC);
`else
  assign sat_acc = 1'b0;
`endif

  always_comb begin
    state_n = state_q;
    ac_n    = ac_q;
    addr_n  = addr_q;
    z_n     = z_q;
    ovf_n   = ovf_q;
    we_n    = we_q;
    maddr_n = maddr_q;
    wdata_n = wdata_q;
    done_n  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.st_req) begin
          ac_n    = bus.AC;
          addr_n  = bus.st_addr;
          z_n     = bus.Z_in;
          ovf_n   = sat_acc;
          we_n    = 1'b1;
          maddr_n = bus.st_addr;
          wdata_n = lo_byte(bus.AC, sat_acc);
          state_n = WR_LO;
        end
      end
      WR_LO: begin
        if (bus.mem_ack) begin
          if (ovf_q) begin
            we_n    = 1'b0;
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            maddr_n = addr_q + AW'(1);
            wdata_n = hi_byte(ac_q);
            state_n = WR_HI;
          end
        end
      end
      WR_HI: begin
        if (bus.mem_ack) begin
          we_n    = 1'b0;
          done_n  = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        we_n    = 1'b0;
        state_n = IDLE;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  // Reset also clears the data-path registers so that the outputs start at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ac_q    <= '0;
      addr_q  <= '0;
      z_q     <= 1'b0;
      ovf_q   <= 1'b0;
      we_q    <= 1'b0;
      maddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      ac_q    <= ac_n;
      addr_q  <= addr_n;
      z_q     <= z_n;
      ovf_q   <= ovf_n;
      we_q    <= we_n;
      maddr_q <= maddr_n;
      wdata_q <= wdata_n;
      done_q  <= done_n;
      busy_q  <= busy_n;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.st_done   = done_q;
  assign bus.z_cap     = z_q;
  assign bus.ovf       = ovf_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = maddr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_acc_store_unit.sv
// Scoreboard bench for acc_store_unit: expected memory writes are queued at request time
// and compared as each we/ack handshake completes.
module tb_acc_store_unit;
  localparam int ACW = 12;
  localparam int DW  = 8;
  localparam int AW  = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  acc_store_if #(.ACW(ACW), .DW(DW), .AW(AW)) bus();

  acc_store_unit #(.ACW(ACW), .DW(DW), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_errs   = 0;
  int  done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: the byte sequence a store of ac at addr must produce.
  task automatic push_store(input logic [7:0] addr, input logic [11:0] ac);
    logic       sat;
    logic [7:0] a1;
`ifdef ACC_STORE_SAT_EN
    sat = (ac[11:8] != 4'h0);
`else
    sat = 1'b0;
`endif
    a1 = addr + 8'd1;
    if (sat) begin
      exp_q.push_back({addr, 8'hFF});
    end else begin
      exp_q.push_back({addr, ac[7:0]});
      exp_q.push_back({a1, {4'h0, ac[11:8]}});
    end
  endtask

  task automatic req(input logic [7:0] a, input logic [11:0] ac, input logic z);
    push_store(a, ac);
    @(posedge clk); #1;
    bus.st_req  = 1'b1;
    bus.st_addr = a;
    bus.AC      = ac;
    bus.Z_in    = z;
    @(posedge clk); #1;
    bus.st_req  = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget);
    for (int i = 0; i < budget && done_cnt == start; i++) @(posedge clk);
    @(posedge clk); #1;
    check("done_count", done_cnt - start, 1);
    check("idle_after_done", bus.busy, 1'b0);
  endtask

  // Handshake monitor: sampled mid-cycle, a handshake completes on the next rising edge.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.mem_we && bus.mem_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", bus.mem_addr, e.addr);
          check("wr_data", bus.mem_wdata, e.data);
        end
      end
      if (bus.st_done) done_cnt++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int d0;
    rst         = 1'b1;
    bus.st_req  = 1'b0;
    bus.st_addr = '0;
    bus.AC      = '0;
    bus.Z_in    = 1'b0;
    bus.mem_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.st_done, 0);
    check("rst_zcap", bus.z_cap, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_we", bus.mem_we, 0);
    check("rst_addr", bus.mem_addr, 0);
    check("rst_wdata", bus.mem_wdata, 0);
    rst = 1'b0;

    // Basic latency with ack tied high
    bus.mem_ack = 1'b1;
`ifndef ACC_STORE_SAT_EN
    d0 = done_cnt;
    req(8'h10, 12'h3A5, 1'b0);
    check("t1_e0_busy", bus.busy, 1);
    check("t1_e0_we", bus.mem_we, 1);
    check("t1_e0_addr", bus.mem_addr, 8'h10);
    check("t1_e0_data", bus.mem_wdata, 8'hA5);
    @(posedge clk); #1;
    check("t1_e1_we", bus.mem_we, 1);
    check("t1_e1_addr", bus.mem_addr, 8'h11);
    check("t1_e1_data", bus.mem_wdata, 8'h03);
    check("t1_e1_done", bus.st_done, 0);
    @(posedge clk); #1;
    check("t1_e2_done", bus.st_done, 1);
    check("t1_e2_we", bus.mem_we, 0);
    check("t1_e2_busy", bus.busy, 1);
    @(posedge clk); #1;
    check("t1_e3_done", bus.st_done, 0);
    check("t1_e3_busy", bus.busy, 0);
    check("t1_done_cnt", done_cnt - d0, 1);
`else
    d0 = done_cnt;
    req(8'h50, 12'h1F0, 1'b0);
    check("s1_e0_we", bus.mem_we, 1);
    check("s1_e0_addr", bus.mem_addr, 8'h50);
    check("s1_e0_data", bus.mem_wdata, 8'hFF);
    check("s1_e0_ovf", bus.ovf, 1);
    @(posedge clk); #1;
    check("s1_e1_done", bus.st_done, 1);
    check("s1_e1_we", bus.mem_we, 0);
    @(posedge clk); #1;
    check("s1_e2_done", bus.st_done, 0);
    check("s1_e2_busy", bus.busy, 0);
    check("s1_done_cnt", done_cnt - d0, 1);
    d0 = done_cnt;
    req(8'h60, 12'h0F0, 1'b0);
    wait_done(d0, 10);
    check("s2_ovf", bus.ovf, 0);
`endif

    // Address wrap
    d0 = done_cnt;
    req(8'hFF, 12'h123, 1'b0);
    wait_done(d0, 10);

    // Delayed ack: outputs stable, requests during busy ignored
    bus.mem_ack = 1'b0;
    d0 = done_cnt;
    req(8'h40, 12'h0C7, 1'b0);
    for (int k = 0; k < 4; k++) begin
      check("t3_lo_we", bus.mem_we, 1);
      check("t3_lo_addr", bus.mem_addr, 8'h40);
      check("t3_lo_data", bus.mem_wdata, 8'hC7);
      bus.st_req  = (k % 2 == 0);
      bus.st_addr = 8'h77;
      bus.AC      = 12'hFFF;
      @(posedge clk); #1;
      bus.st_req  = 1'b0;
    end
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("t3_hi_we", bus.mem_we, 1);
      check("t3_hi_addr", bus.mem_addr, 8'h41);
      check("t3_hi_data", bus.mem_wdata, 8'h00);
      bus.st_req = (k % 2 == 1);
      @(posedge clk); #1;
      bus.st_req = 1'b0;
    end
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    wait_done(d0, 5);
    bus.mem_ack = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("t3_no_extra_we", bus.mem_we, 0);
    check("t3_single_done", done_cnt - d0, 1);

    // Capture isolation for AC and Z
    d0 = done_cnt;
    req(8'h20, 12'h000, 1'b1);
    bus.AC   = 12'hFFF;
    bus.Z_in = 1'b0;
    wait_done(d0, 10);
    check("t4_zcap", bus.z_cap, 1);

    // Reset during WR_HI with ack low
    bus.mem_ack = 1'b0;
    d0 = done_cnt;
    req(8'h30, 12'h0AB, 1'b0);
    bus.mem_ack = 1'b1;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("t5_pre_we", bus.mem_we, 1);
    check("t5_pre_addr", bus.mem_addr, 8'h31);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    check("t5_rst_we", bus.mem_we, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_done", bus.st_done, 0);
    repeat (3) @(posedge clk);
    #1;
    check("t5_no_done", done_cnt - d0, 0);
    bus.mem_ack = 1'b1;
    d0 = done_cnt;
    req(8'h32, 12'h2CD, 1'b1);
    wait_done(d0, 10);
    check("t5_zcap", bus.z_cap, 1);

    repeat (3) @(posedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
